// File: rtl/octree_branch_writer_if.sv
// Request, status and BRAM port A bundle for the octree branch-table write engine.
// The slave modport is the engine's view; master is the requester/BRAM side.
interface octree_branch_writer_if #(
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 16,
    parameter int META_W = 24
);
    localparam int ENTRY_W = META_W + 8 * PTR_W;

    logic                clear;
    logic                busy;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_parent;
    logic [2:0]          req_octant;
    logic [PTR_W-1:0]    req_child;
    logic                req_meta_we;
    logic [META_W-1:0]   req_meta;
    logic                done;
    logic                err;
    logic                ena;
    logic                wea;
    logic [ADDR_W-1:0]   addra;
    logic [ENTRY_W-1:0]  dina;
    logic [ENTRY_W-1:0]  douta;

    modport slave (
        input  clear, req_valid, req_parent, req_octant, req_child,
               req_meta_we, req_meta, douta,
        output busy, req_ready, done, err, ena, wea, addra, dina
    );

    modport master (
        output clear, req_valid, req_parent, req_octant, req_child,
               req_meta_we, req_meta, douta,
        input  busy, req_ready, done, err, ena, wea, addra, dina
    );
endinterface

// File: rtl/octree_branch_writer.sv
// Write-side engine for the octree branch table: serialises link-child requests into
// read-modify-write cycles on BRAM port A and provides a bulk table clear.
module octree_branch_writer #(
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 16,
    parameter int META_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    octree_branch_writer_if.slave bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRY_W = META_W + 8 * PTR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RD, MOD, WR} state_t;

    state_t              state, state_next;
    logic [ADDR_W:0]     clr_cnt;
    logic [ADDR_W-1:0]   parent_q;
    logic [2:0]          octant_q;
    logic [PTR_W-1:0]    child_q;
    logic                meta_we_q;
    logic [META_W-1:0]   meta_q;
    logic [ENTRY_W-1:0]  new_q, new_d;
    logic                done_q, err_q, done_d, err_d;
    logic                ena_c, wea_c;
    logic [ADDR_W-1:0]   addra_c;
    logic [ENTRY_W-1:0]  dina_c;
    logic [PTR_W-1:0]    old_ptr;
    logic                slot_conflict;
    logic                accept;

    // A slot is only refused when it already points at a different child.
    assign old_ptr       = bus.douta[META_W + PTR_W * octant_q +: PTR_W];
    assign slot_conflict = (child_q != '0) && (old_ptr != '0) && (old_ptr != child_q);
    assign accept        = (state == IDLE) && !bus.clear && bus.req_valid;

    always_comb begin
        state_next = state;
        done_d     = 1'b0;
        err_d      = 1'b0;
        new_d      = new_q;
        ena_c      = 1'b0;
        wea_c      = 1'b0;
        addra_c    = '0;
        dina_c     = '0;
        case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_next = CLEAR;
                end else if (bus.req_valid) begin
                    state_next = RD;
                end
            end
            CLEAR: begin
                ena_c   = 1'b1;
                wea_c   = 1'b1;
                addra_c = clr_cnt[ADDR_W-1:0];
                if (clr_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            RD: begin
                ena_c      = 1'b1;
                addra_c    = parent_q;
                state_next = MOD;
            end
            MOD: begin
                if (slot_conflict) begin
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    state_next = IDLE;
                end else begin
                    new_d = bus.douta;
                    new_d[META_W + PTR_W * octant_q +: PTR_W] = child_q;
                    if (meta_we_q) begin
                        new_d[META_W-1:0] = meta_q;
                    end
                    state_next = WR;
                end
            end
            WR: begin
                ena_c      = 1'b1;
                wea_c      = 1'b1;
                addra_c    = parent_q;
                dina_c     = new_q;
                done_d     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_d;
            err_q  <= err_d;
            if (state == IDLE && bus.clear) begin
                clr_cnt <= '0;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Request fields are held for the whole RMW; new_q only matters in WR.
    always_ff @(posedge clk) begin
        if (accept) begin
            parent_q  <= bus.req_parent;
            octant_q  <= bus.req_octant;
            child_q   <= bus.req_child;
            meta_we_q <= bus.req_meta_we;
            meta_q    <= bus.req_meta;
        end
        new_q <= new_d;
    end

    assign bus.busy      = (state != IDLE);
    assign bus.req_ready = (state == IDLE) && !bus.clear;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.ena       = ena_c;
    assign bus.wea       = wea_c;
    assign bus.addra     = addra_c;
    assign bus.dina      = dina_c;
endmodule
